// File: rtl/counter_sequencer_pkg.sv
// Shared types for the address counter and its burst sequencer.
package counter_types;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INC  = 2'd1,
    LOAD = 2'd2
  } cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } seq_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester preferred on a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic rr_ptr;

  always_comb begin
    grant_idx = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = rr_ptr;
      default: grant_idx = 1'b0;
    endcase
    grant = (req == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);
  end

  // After any grant the other requester becomes preferred, even if it was not asking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 1'b0;
    end else if (advance && (req != 2'b00)) begin
      rr_ptr <= ~grant_idx;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Burst-fetch controller: grants one of two requesters, then steps the address
// counter through the burst while presenting each address on a valid/ready port.
module counter_sequencer
  import counter_types::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req,
  input  logic [2*ADDR_W-1:0] req_base,
  input  logic [2*LEN_W-1:0]  req_len,
  output logic [1:0]          ack,
  output logic [1:0]          done,
  output cmd_t                cmd,
  output logic [ADDR_W-1:0]   load_addr,
  input  logic [ADDR_W-1:0]   addr,
  output logic                rd_valid,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_ready,
  output logic                rd_owner,
  output logic                busy
);

  seq_state_t        state;
  logic              owner;
  logic [LEN_W-1:0]  remaining;
  logic [1:0]        done_q;
  logic [1:0]        grant;
  logic              grant_idx;
  logic [ADDR_W-1:0] sel_base;
  logic [LEN_W-1:0]  sel_len;
  logic              last_beat;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .advance   (state == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_base  = grant_idx ? req_base[2*ADDR_W-1:ADDR_W] : req_base[ADDR_W-1:0];
  assign sel_len   = grant_idx ? req_len[2*LEN_W-1:LEN_W]    : req_len[LEN_W-1:0];
  assign last_beat = (remaining == LEN_W'(1));

  assign rd_valid = (state == XFER);
  assign busy     = (state == XFER);
  assign rd_addr  = addr;
  assign rd_owner = owner;
  assign done     = done_q;

  // Grant and counter commands are combinational; held quiet while reset is asserted.
  always_comb begin
    cmd       = NONE;
    load_addr = '0;
    ack       = 2'b00;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            ack = grant;
            if (sel_len != '0) begin
              cmd       = LOAD;
              load_addr = sel_base;
            end
          end
        end
        XFER: begin
          if (rd_ready) begin
            cmd = last_beat ? NONE : INC;
          end
        end
        default: cmd = NONE;
      endcase
    end
  end

  // A zero-length grant never leaves IDLE but still reports completion next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      remaining <= '0;
      done_q    <= 2'b00;
    end else begin
      done_q <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner     <= grant_idx;
            remaining <= sel_len;
            if (sel_len == '0) begin
              done_q <= grant;
            end else begin
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (rd_ready) begin
            if (last_beat) begin
              remaining     <= '0;
              state         <= IDLE;
              done_q[owner] <= 1'b1;
            end else begin
              remaining <= remaining - LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
